// File: rtl/tp_pkg.sv
// Shared definitions for the test-pattern generator: pattern select
// encodings, colour-bar table, default 720p timing and a helper that sizes
// the pixel/line counters.
package tp_pkg;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'b00,
        PAT_GRAD  = 2'b01,
        PAT_CHECK = 2'b10,
        PAT_LIVE  = 2'b11
    } pat_sel_t;

    // Default 1280x720 timing
    localparam int unsigned TP_H_ACTIVE  = 1280;
    localparam int unsigned TP_H_FP      = 110;
    localparam int unsigned TP_H_SYNC    = 40;
    localparam int unsigned TP_H_BP      = 220;
    localparam int unsigned TP_V_ACTIVE  = 720;
    localparam int unsigned TP_V_FP      = 5;
    localparam int unsigned TP_V_SYNC    = 5;
    localparam int unsigned TP_V_BP      = 20;
    localparam bit          TP_SYNC_POL  = 1'b1;
    localparam int unsigned TP_CHK_SHIFT = 5;

    // Bar colours as {R,G,B}; index 0 is the leftmost bar.
    localparam logic [7:0][23:0] BAR_TABLE = {
        24'h000000,   // 7 black
        24'h0000FF,   // 6 blue
        24'hFF0000,   // 5 red
        24'hFF00FF,   // 4 magenta
        24'h00FF00,   // 3 green
        24'h00FFFF,   // 2 cyan
        24'hFFFF00,   // 1 yellow
        24'hFFFFFF    // 0 white
    };

    // Counter width: enough for the total, but never narrower than the
    // bits the gradient ([7:0]) and checker ([chk_shift]) look at.
    function automatic int unsigned tp_cnt_width(input int unsigned total,
                                                 input int unsigned chk_shift);
        int unsigned w;
        w = $clog2(total);
        if (w < 8) w = 8;
        if (w < chk_shift + 1) w = chk_shift + 1;
        return w;
    endfunction

endpackage

// File: rtl/tp_timing_counter.sv
// Pixel/line counters for the pattern generator plus combinational decode
// of the active region, sync windows and the last pixel of the frame.
module tp_timing_counter #(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    parameter int unsigned CW       = 11
) (
    input  logic          pix_clk_i,
    input  logic          rst_n_i,
    output logic [CW-1:0] h_cnt_o,
    output logic [CW-1:0] v_cnt_o,
    output logic          active_o,
    output logic          hsync_o,
    output logic          vsync_o,
    output logic          frame_end_o
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    logic [CW-1:0] h_cnt_q, h_cnt_d;
    logic [CW-1:0] v_cnt_q, v_cnt_d;
    logic          h_last, v_last;

    assign h_last = (h_cnt_q == CW'(H_TOTAL - 1));
    assign v_last = (v_cnt_q == CW'(V_TOTAL - 1));

    // Next-count logic: line counter only advances on the horizontal wrap
    always_comb begin
        h_cnt_d = h_last ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_last) begin
            v_cnt_d = v_last ? '0 : v_cnt_q + 1'b1;
        end
    end

    // Counter registers
    always_ff @(posedge pix_clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign active_o    = (h_cnt_q < CW'(H_ACTIVE)) && (v_cnt_q < CW'(V_ACTIVE));
    assign hsync_o     = (h_cnt_q >= CW'(HS_START)) && (h_cnt_q < CW'(HS_END));
    // vsync depends on the line count only, so it toggles on h_cnt = 0
    assign vsync_o     = (v_cnt_q >= CW'(VS_START)) && (v_cnt_q < CW'(VS_END));
    assign frame_end_o = h_last && v_last;

endmodule

// File: rtl/tp_pattern_gen.sv
// Video test-pattern generator: timing, pattern select synchronizer,
// frame-aligned pattern latch and registered sync/DE/RGB outputs.
// Optional build macro TP_FRAME_CNT_EN adds a frame counter output and
// makes the gradient scroll horizontally by one pixel per frame.
module tp_pattern_gen
    import tp_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = TP_H_ACTIVE,
    parameter int unsigned H_FP      = TP_H_FP,
    parameter int unsigned H_SYNC    = TP_H_SYNC,
    parameter int unsigned H_BP      = TP_H_BP,
    parameter int unsigned V_ACTIVE  = TP_V_ACTIVE,
    parameter int unsigned V_FP      = TP_V_FP,
    parameter int unsigned V_SYNC    = TP_V_SYNC,
    parameter int unsigned V_BP      = TP_V_BP,
    parameter bit          SYNC_POL  = TP_SYNC_POL,
    parameter int unsigned CHK_SHIFT = TP_CHK_SHIFT
) (
    input  logic       pix_clk_tp,
    input  logic       rst_n,
    input  logic [1:0] Img_Select,
    output logic       hsync_tp,
    output logic       vsync_tp,
    output logic       de_tp,
    output logic [7:0] redh,
    output logic [7:0] greenh,
    output logic [7:0] blueh
`ifdef TP_FRAME_CNT_EN
    ,
    output logic [7:0] frame_cnt
`endif
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned CW      = tp_cnt_width((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL,
                                                   CHK_SHIFT);
    localparam int unsigned BAR_W   = H_ACTIVE / 8;

    logic [CW-1:0] h_cnt, v_cnt;
    logic          active, hsync, vsync, frame_end;

    logic [1:0]    sel_meta_q, sel_sync_q;
    pat_sel_t      pat_sel_q;
    logic [2:0]    bar_idx;
    logic [23:0]   rgb_d;
    logic [23:0]   rgb_q;
    logic          de_q, hsync_q, vsync_q;

    tp_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CW       (CW)
    ) u_timing (
        .pix_clk_i   (pix_clk_tp),
        .rst_n_i     (rst_n),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .active_o    (active),
        .hsync_o     (hsync),
        .vsync_o     (vsync),
        .frame_end_o (frame_end)
    );

`ifdef TP_FRAME_CNT_EN
    logic [7:0] frame_cnt_q;

    // Frame counter advances on the same edge the pattern latch updates
    always_ff @(posedge pix_clk_tp or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (frame_end) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    // Switch synchronizer; pattern only changes between frames
    always_ff @(posedge pix_clk_tp or negedge rst_n) begin
        if (!rst_n) begin
            sel_meta_q <= 2'b00;
            sel_sync_q <= 2'b00;
            pat_sel_q  <= PAT_BARS;
        end else begin
            sel_meta_q <= Img_Select;
            sel_sync_q <= sel_meta_q;
            if (frame_end) begin
                pat_sel_q <= pat_sel_t'(sel_sync_q);
            end
        end
    end

    assign bar_idx = 3'(h_cnt / CW'(BAR_W));

    // Pixel colour for the current counter position; blank outside active
    always_comb begin
        rgb_d = 24'h000000;
        if (active) begin
            case (pat_sel_q)
                PAT_BARS:  rgb_d = BAR_TABLE[bar_idx];
`ifdef TP_FRAME_CNT_EN
                PAT_GRAD:  rgb_d = {h_cnt[7:0] + frame_cnt_q, v_cnt[7:0], 8'h80};
`else
                PAT_GRAD:  rgb_d = {h_cnt[7:0], v_cnt[7:0], 8'h80};
`endif
                PAT_CHECK: rgb_d = (h_cnt[CHK_SHIFT] ^ v_cnt[CHK_SHIFT]) ? 24'hFFFFFF
                                                                          : 24'h000000;
                PAT_LIVE:  rgb_d = 24'h000000;
                default:   rgb_d = 24'h000000;
            endcase
        end
    end

    // Output registers: one cycle behind the counters
    always_ff @(posedge pix_clk_tp or negedge rst_n) begin
        if (!rst_n) begin
            de_q    <= 1'b0;
            hsync_q <= ~SYNC_POL;
            vsync_q <= ~SYNC_POL;
            rgb_q   <= 24'h000000;
        end else begin
            de_q    <= active;
            hsync_q <= hsync ? SYNC_POL : ~SYNC_POL;
            vsync_q <= vsync ? SYNC_POL : ~SYNC_POL;
            rgb_q   <= rgb_d;
        end
    end

    assign de_tp    = de_q;
    assign hsync_tp = hsync_q;
    assign vsync_tp = vsync_q;
    assign redh     = rgb_q[23:16];
    assign greenh   = rgb_q[15:8];
    assign blueh    = rgb_q[7:0];

endmodule

// File: doc/tp_pattern_gen.md
TP_PATTERN_GEN -- requirements
Module: tp_pattern_gen

Interface
REQ-001 The parameters SHALL be:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch
- H_SYNC, 40, hsync width
- H_BP, 220, horizontal back porch
- V_ACTIVE, 720, active lines
- V_FP, 5, vertical front porch
- V_SYNC, 5, vsync width
- V_BP, 20, vertical back porch
- SYNC_POL, 1, active level of hsync_tp/vsync_tp
- CHK_SHIFT, 5, checker square size is 2^CHK_SHIFT pixels
REQ-002 The ports SHALL be:
- pix_clk_tp  in  1  pixel clock; single clock domain
- rst_n  in  1  reset, asynchronous assert, active-low
- Img_Select  in  2  pattern select from switches, asynchronous
- hsync_tp  out  1  horizontal sync
- vsync_tp  out  1  vertical sync
- de_tp  out  1  data enable, high in active region
- redh  out  8  red pixel
- greenh  out  8  green pixel
- blueh  out  8  blue pixel
- frame_cnt  out  8  frame counter, present only with TP_FRAME_CNT_EN

Function
REQ-003 The block SHALL keep h_cnt in 0..H_TOTAL-1 (H_TOTAL = sum of H_*), incrementing every clock and wrapping to 0.
REQ-004 The block SHALL keep v_cnt in 0..V_TOTAL-1, incrementing only when h_cnt wraps; v_cnt wraps to 0 when h_cnt and v_cnt are both at their maximum.
REQ-005 Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE.
REQ-006 hsync is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync is active for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, aligned to the h_cnt = 0 line boundary.
REQ-007 All outputs SHALL be registered; the outputs at edge n+1 reflect the counters at edge n (1-cycle latency).
REQ-008 Img_Select SHALL pass through a 2-flop synchronizer, then be latched into pat_sel only on the last pixel of a frame (h_cnt = H_TOTAL-1, v_cnt = V_TOTAL-1); mid-frame changes never alter the current frame.
REQ-009 pat_sel 00, colour bars: 8 bars of width H_ACTIVE/8, left to right white, yellow, cyan, green, magenta, red, blue, black; each component is 0xFF or 0x00.
REQ-010 pat_sel 01, gradient: red = h_cnt[7:0], green = v_cnt[7:0], blue = 0x80.
REQ-011 pat_sel 10, checker: all components 0xFF when h_cnt[CHK_SHIFT] XOR v_cnt[CHK_SHIFT] = 1, else 0x00.
REQ-012 pat_sel 11 (live, selected downstream): RGB = 0x00; timing keeps running.
REQ-013 Outside the active region, RGB SHALL be 0x00 regardless of pattern.

Reset
REQ-014 On rst_n low: h_cnt = 0, v_cnt = 0, pat_sel = 00, synchronizer = 00, de_tp = 0, hsync_tp = vsync_tp = !SYNC_POL, RGB = 0x00, frame_cnt = 0.
REQ-015 Reset mid-frame SHALL abort the frame immediately; after rst_n rises, the first rising edge drives de_tp = 1 with white (pixel 0,0 of colour bars).

Configuration
REQ-016 With TP_FRAME_CNT_EN defined, frame_cnt increments (wrapping 255 to 0) at each frame wrap, and the gradient red becomes h_cnt[7:0] + frame_cnt, modulo 256 (scrolling).
REQ-017 Without TP_FRAME_CNT_EN, the frame_cnt port and its register are absent and the gradient is static per REQ-010.

Structure
REQ-018 Package tp_pkg SHALL hold the pattern select encodings (PAT_BARS, PAT_GRAD, PAT_CHECK, PAT_LIVE), the 8-entry bar colour table and the default 720p timing constants.
REQ-019 The counters and sync/active decode SHALL live in sub-module tp_timing_counter; tp_pattern_gen instantiates it and adds the synchronizer, pattern latch and pixel registers.

Verification
REQ-020 The bench SHALL use small timing (H: 16/2/3/3, V: 8/1/2/1, CHK_SHIFT = 1, SYNC_POL = 1) and cover:
- Reset release -> de_tp = 1 at edge 1 for 16 clocks, then low for 8; hsync_tp high on clocks 19-21; period 24 clocks.
- Full frame -> 288 clocks; vsync_tp high for 48 clocks starting at line 9, clock 0; de_tp high 128 clocks total.
- Img_Select = 00 -> active line reads FFFFFF, FFFFFF, FFFF00, FFFF00, 00FFFF, and so on (2 px per bar); last 2 px read 000000.
- Img_Select 00 -> 10 at mid-frame line 3 -> rest of the frame stays bars; next frame pixel (0,0) = 000000 and (2,0) = FFFFFF.
- rst_n pulsed low at line 5, pixel 7 -> outputs take reset values asynchronously; the restart matches the first scenario.
- With TP_FRAME_CNT_EN and gradient -> frame 3, pixel (4,0) red = 0x07; frame_cnt wraps from 255 to 0.
